// File: rtl/sram_1r1w_secded_pkg.sv
// Shared types and helpers for the SECDED-protected 1R1W SRAM.
package sram_1r1w_secded_pkg;

    typedef enum logic [1:0] {
        NONE          = 2'd0,
        CORRECTED     = 2'd1,
        UNCORRECTABLE = 2'd2
    } ecc_status_t;

    typedef enum logic {
        SCRUB_IDLE    = 1'b0,
        SCRUB_PENDING = 1'b1
    } scrub_state_t;

    // Hamming bits r (smallest r with 2^r >= data_width + r + 1) plus overall parity
    function automatic int secded_check_width(input int data_width);
        int width;
        width = 32'sd0;
        for (int r = 31; r >= 1; r--) begin
            if ((32'sd1 <<< r) >= data_width + r + 32'sd1) width = r + 32'sd1;
        end
        return width;
    endfunction

endpackage

// File: rtl/secded_codec.sv
// Combinational Hamming SECDED encoder/decoder; codeword layout is {overall parity, hamming bits, data}.
module secded_codec
    import sram_1r1w_secded_pkg::*;
#(
    parameter int  DATA_WIDTH  = 32,
    localparam int CHECK_WIDTH = secded_check_width(DATA_WIDTH),
    localparam int CODE_WIDTH  = DATA_WIDTH + CHECK_WIDTH
) (
    input  logic [CODE_WIDTH-1:0] code_i,
    output logic [CODE_WIDTH-1:0] enc_code_o,
    output logic [CODE_WIDTH-1:0] fix_code_o,
    output ecc_status_t           status_o
);
    localparam int HAM_WIDTH = CHECK_WIDTH - 1;

    // Data bit i sits at the i-th non-power-of-two Hamming position; bit j of that position selects coverage
    function automatic logic [HAM_WIDTH*DATA_WIDTH-1:0] build_cover();
        logic [HAM_WIDTH*DATA_WIDTH-1:0] m;
        int pos;
        m   = '0;
        pos = 32'sd2;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            pos = pos + 32'sd1;
            while ((pos & (pos - 32'sd1)) == 32'sd0) pos = pos + 32'sd1;
            for (int j = 0; j < HAM_WIDTH; j++) m[j*DATA_WIDTH + i] = pos[j];
        end
        return m;
    endfunction

    localparam logic [HAM_WIDTH*DATA_WIDTH-1:0] COVER = build_cover();

    logic [DATA_WIDTH-1:0] data_s;
    logic [HAM_WIDTH-1:0]  calc_s;
    logic [HAM_WIDTH-1:0]  syn_s;
    logic                  par_bad_s;
    logic [HAM_WIDTH-1:0]  pos_v;

    assign data_s     = code_i[DATA_WIDTH-1:0];
    assign syn_s      = calc_s ^ code_i[DATA_WIDTH +: HAM_WIDTH];
    assign par_bad_s  = ^code_i;
    assign enc_code_o = {^{calc_s, data_s}, calc_s, data_s};

    // Hamming check bits recomputed from the data field
    always_comb begin
        calc_s = '0;
        for (int j = 0; j < HAM_WIDTH; j++) begin
            calc_s[j] = ^(data_s & COVER[j*DATA_WIDTH +: DATA_WIDTH]);
        end
    end

    // Bad overall parity means one flipped bit: syndrome 0 is the parity bit itself
    always_comb begin
        fix_code_o = code_i;
        status_o   = NONE;
        pos_v      = '0;
        if (par_bad_s) begin
            status_o = CORRECTED;
            if (syn_s == '0) begin
                fix_code_o[CODE_WIDTH-1] = ~code_i[CODE_WIDTH-1];
            end else begin
                for (int j = 0; j < HAM_WIDTH; j++) begin
                    if (syn_s == HAM_WIDTH'(32'd1 << j)) fix_code_o[DATA_WIDTH + j] = ~code_i[DATA_WIDTH + j];
                end
                for (int i = 0; i < DATA_WIDTH; i++) begin
                    for (int j = 0; j < HAM_WIDTH; j++) pos_v[j] = COVER[j*DATA_WIDTH + i];
                    if (syn_s == pos_v) fix_code_o[i] = ~code_i[i];
                end
            end
        end else if (syn_s != '0) begin
            status_o = UNCORRECTABLE;
        end else begin
            status_o = NONE;
        end
    end

endmodule

// File: rtl/sram_1r1w_secded.sv
// 1R1W SRAM with SECDED correction, one-entry scrubber and saturating error counters.
// Define SRAM_ECC_INJECT_EN to add inject_en/inject_mask for corrupting external writes.
module sram_1r1w_secded
    import sram_1r1w_secded_pkg::*;
#(
    parameter int    DATA_WIDTH        = 32,
    parameter int    SIZE              = 1024,
    parameter string READ_DURING_WRITE = "NEW_DATA",
    parameter int    ADDR_WIDTH        = $clog2(SIZE),
    parameter int    COUNT_WIDTH       = 16,
    localparam int   CHECK_WIDTH       = secded_check_width(DATA_WIDTH),
    localparam int   CODE_WIDTH        = DATA_WIDTH + CHECK_WIDTH
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   read_en,
    input  logic [ADDR_WIDTH-1:0]  read_addr,
    output logic [DATA_WIDTH-1:0]  read_data,
    input  logic                   write_en,
    input  logic [ADDR_WIDTH-1:0]  write_addr,
    input  logic [DATA_WIDTH-1:0]  write_data,
`ifdef SRAM_ECC_INJECT_EN
    input  logic                   inject_en,
    input  logic [CODE_WIDTH-1:0]  inject_mask,
`endif
    output logic                   ecc_corrected,
    output logic                   ecc_uncorrectable,
    output logic [ADDR_WIDTH-1:0]  ecc_err_addr,
    output logic [COUNT_WIDTH-1:0] corr_count,
    output logic [COUNT_WIDTH-1:0] uncorr_count,
    output logic                   scrub_drop
);
    localparam bit BYPASS_EN = (READ_DURING_WRITE == "NEW_DATA");

    logic [CODE_WIDTH-1:0]  mem_q [SIZE];
    logic [CODE_WIDTH-1:0]  enc_code_s, wr_code_s, rd_code_d, rd_code_q, fix_code_s;
    logic [CODE_WIDTH-1:0]  enc_fix_unused_s, dec_enc_unused_s, scrub_code_q;
    ecc_status_t            enc_status_unused_s, dec_status_s;
    logic [ADDR_WIDTH-1:0]  rd_addr_q, scrub_addr_q, err_addr_q;
    logic [COUNT_WIDTH-1:0] corr_cnt_q, uncorr_cnt_q;
    logic                   rd_valid_q, corr_s, uncorr_s, accept_s;
    logic                   scrub_pend_s, scrub_wr_s, scrub_cancel_s, scrub_retire_s;
    scrub_state_t           scrub_state_q;

    secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_enc (
        .code_i     ({{CHECK_WIDTH{1'b0}}, write_data}),
        .enc_code_o (enc_code_s),
        .fix_code_o (enc_fix_unused_s),
        .status_o   (enc_status_unused_s)
    );

    secded_codec #(.DATA_WIDTH(DATA_WIDTH)) u_dec (
        .code_i     (rd_code_q),
        .enc_code_o (dec_enc_unused_s),
        .fix_code_o (fix_code_s),
        .status_o   (dec_status_s)
    );

    // Codeword actually stored by an external write
    always_comb begin
        wr_code_s = enc_code_s;
`ifdef SRAM_ECC_INJECT_EN
        if (inject_en) begin
            wr_code_s = enc_code_s ^ inject_mask;
        end else begin
            wr_code_s = enc_code_s;
        end
`endif
    end

    assign scrub_pend_s   = (scrub_state_q == SCRUB_PENDING);
    assign scrub_cancel_s = scrub_pend_s && write_en && (write_addr == scrub_addr_q);
    assign scrub_wr_s     = scrub_pend_s && !write_en && !reset;
    assign scrub_retire_s = scrub_cancel_s || scrub_wr_s;
    assign corr_s         = rd_valid_q && (dec_status_s == CORRECTED);
    assign uncorr_s       = rd_valid_q && (dec_status_s == UNCORRECTABLE);
    // A correction racing an external write to the same word must not overwrite it later
    assign accept_s       = corr_s && !(write_en && (write_addr == rd_addr_q));

    assign read_data         = fix_code_s[DATA_WIDTH-1:0];
    assign ecc_corrected     = corr_s;
    assign ecc_uncorrectable = uncorr_s;
    assign scrub_drop        = corr_s && scrub_pend_s && !scrub_retire_s;
    assign ecc_err_addr      = err_addr_q;
    assign corr_count        = corr_cnt_q;
    assign uncorr_count      = uncorr_cnt_q;

    // Storage array; external writes always win over the scrubber
    always_ff @(posedge clk) begin
        if (write_en) begin
            mem_q[write_addr] <= wr_code_s;
        end else if (scrub_wr_s) begin
            mem_q[scrub_addr_q] <= scrub_code_q;
        end
    end

    // Same-address bypass returns a clean codeword so the bypassed read reports no error
    always_comb begin
        rd_code_d = mem_q[read_addr];
        if (BYPASS_EN && write_en && (write_addr == read_addr)) begin
            rd_code_d = enc_code_s;
        end else if (BYPASS_EN && scrub_wr_s && (scrub_addr_q == read_addr)) begin
            rd_code_d = scrub_code_q;
        end else begin
            rd_code_d = mem_q[read_addr];
        end
    end

    // Read pipeline register: raw codeword and address for next-cycle decode
    always_ff @(posedge clk) begin
        if (reset) begin
            rd_valid_q <= 1'b0;
            rd_code_q  <= '0;
            rd_addr_q  <= '0;
        end else begin
            rd_valid_q <= read_en;
            if (read_en) begin
                rd_code_q <= rd_code_d;
                rd_addr_q <= read_addr;
            end
        end
    end

    // Error address and saturating statistics
    always_ff @(posedge clk) begin
        if (reset) begin
            err_addr_q   <= '0;
            corr_cnt_q   <= '0;
            uncorr_cnt_q <= '0;
        end else begin
            if (corr_s || uncorr_s) err_addr_q <= rd_addr_q;
            if (corr_s && (corr_cnt_q != '1)) corr_cnt_q <= corr_cnt_q + COUNT_WIDTH'(1);
            if (uncorr_s && (uncorr_cnt_q != '1)) uncorr_cnt_q <= uncorr_cnt_q + COUNT_WIDTH'(1);
        end
    end

    // Scrubber: hold one corrected codeword until a write-free cycle or a cancelling write
    always_ff @(posedge clk) begin
        if (reset) begin
            scrub_state_q <= SCRUB_IDLE;
            scrub_addr_q  <= '0;
            scrub_code_q  <= '0;
        end else begin
            case (scrub_state_q)
                SCRUB_IDLE: begin
                    if (accept_s) begin
                        scrub_state_q <= SCRUB_PENDING;
                        scrub_addr_q  <= rd_addr_q;
                        scrub_code_q  <= fix_code_s;
                    end
                end
                SCRUB_PENDING: begin
                    if (scrub_retire_s && accept_s) begin
                        scrub_addr_q <= rd_addr_q;
                        scrub_code_q <= fix_code_s;
                    end else if (scrub_retire_s) begin
                        scrub_state_q <= SCRUB_IDLE;
                    end
                end
                default: scrub_state_q <= SCRUB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_1r1w_secded.sv
// Directed scoreboard bench for sram_1r1w_secded; errors are planted via inject ports or backdoor.
module tb_sram_1r1w_secded;
    localparam int CW  = 6;
    localparam int SAT = 63;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          read_en = 1'b0;
    logic [9:0]    read_addr = 10'd0;
    logic [31:0]   read_data;
    logic          write_en = 1'b0;
    logic [9:0]    write_addr = 10'd0;
    logic [31:0]   write_data = 32'd0;
`ifdef SRAM_ECC_INJECT_EN
    logic          inject_en = 1'b0;
    logic [38:0]   inject_mask = 39'd0;
`endif
    logic          ecc_corrected, ecc_uncorrectable, scrub_drop;
    logic [9:0]    ecc_err_addr;
    logic [CW-1:0] corr_count, uncorr_count;

    sram_1r1w_secded #(.COUNT_WIDTH(CW)) dut (
        .clk               (clk),
        .reset             (reset),
        .read_en           (read_en),
        .read_addr         (read_addr),
        .read_data         (read_data),
        .write_en          (write_en),
        .write_addr        (write_addr),
        .write_data        (write_data),
`ifdef SRAM_ECC_INJECT_EN
        .inject_en         (inject_en),
        .inject_mask       (inject_mask),
`endif
        .ecc_corrected     (ecc_corrected),
        .ecc_uncorrectable (ecc_uncorrectable),
        .ecc_err_addr      (ecc_err_addr),
        .corr_count        (corr_count),
        .uncorr_count      (uncorr_count),
        .scrub_drop        (scrub_drop)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic        corr;
        logic        unc;
        logic        drop;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   m_corr  = 0;
    int   m_unc   = 0;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic expect_read(input logic [31:0] d, input logic c, input logic u, input logic dr);
        exp_t e;
        e.data = d; e.corr = c; e.unc = u; e.drop = dr;
        sb_q.push_back(e);
        if (c && m_corr < SAT) m_corr++;
        if (u && m_unc < SAT) m_unc++;
    endtask

    task automatic tick();
        logic had_read;
        exp_t e;
        had_read = read_en;
        @(posedge clk);
        #1;
        if (had_read) begin
            if (sb_q.size() == 0) begin
                n_tests++;
                n_fail++;
                $error("FAIL sb_underflow observed=empty expected=entry");
            end else begin
                e = sb_q.pop_front();
                chk("read_data", 64'(read_data), 64'(e.data));
                chk("ecc_corrected", 64'(ecc_corrected), 64'(e.corr));
                chk("ecc_uncorrectable", 64'(ecc_uncorrectable), 64'(e.unc));
                chk("scrub_drop", 64'(scrub_drop), 64'(e.drop));
            end
        end
    endtask

    task automatic wr(input logic [9:0] a, input logic [31:0] d);
        write_en = 1'b1; write_addr = a; write_data = d;
        tick();
        write_en = 1'b0;
    endtask

    task automatic rd(input logic [9:0] a, input logic [31:0] d, input logic c, input logic u, input logic dr);
        read_en = 1'b1; read_addr = a;
        expect_read(d, c, u, dr);
        tick();
        read_en = 1'b0;
    endtask

    task automatic corrupt_wr(input logic [9:0] a, input logic [31:0] d, input logic [38:0] m);
`ifdef SRAM_ECC_INJECT_EN
        inject_en = 1'b1; inject_mask = m;
        wr(a, d);
        inject_en = 1'b0;
`else
        wr(a, d);
        dut.mem_q[a] = dut.mem_q[a] ^ m;
`endif
    endtask

    task automatic chk_stats(input logic [9:0] ea);
        chk("ecc_err_addr", 64'(ecc_err_addr), 64'(ea));
        chk("corr_count", 64'(corr_count), 64'(m_corr));
        chk("uncorr_count", 64'(uncorr_count), 64'(m_unc));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        tick(); tick();
        chk("rst_read_data", 64'(read_data), 64'd0);
        chk("rst_corr", 64'(ecc_corrected), 64'd0);
        chk("rst_unc", 64'(ecc_uncorrectable), 64'd0);
        chk("rst_drop", 64'(scrub_drop), 64'd0);
        chk_stats(10'd0);
        reset = 1'b0;

        // clean write/read
        wr(10'd5, 32'hDEADBEEF);
        rd(10'd5, 32'hDEADBEEF, 1'b0, 1'b0, 1'b0);
        tick();
        chk_stats(10'd0);

        // single data-bit error, then write-back with write_en idle
        corrupt_wr(10'd9, 32'h12345678, 39'd1 << 3);
        rd(10'd9, 32'h12345678, 1'b1, 1'b0, 1'b0);
        tick();
        chk_stats(10'd9);
        tick();
        rd(10'd9, 32'h12345678, 1'b0, 1'b0, 1'b0);

        // check-bit and overall-parity-bit errors leave data untouched
        corrupt_wr(10'd11, 32'h0F0F0F0F, 39'd1 << 33);
        rd(10'd11, 32'h0F0F0F0F, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        corrupt_wr(10'd12, 32'hF00DFACE, 39'd1 << 38);
        rd(10'd12, 32'hF00DFACE, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        rd(10'd11, 32'h0F0F0F0F, 1'b0, 1'b0, 1'b0);
        rd(10'd12, 32'hF00DFACE, 1'b0, 1'b0, 1'b0);
        tick();
        chk_stats(10'd12);

        // double-bit error: raw data, no write-back
        corrupt_wr(10'd2, 32'hCAFEF00D, 39'h3);
        rd(10'd2, 32'hCAFEF00E, 1'b0, 1'b1, 1'b0);
        tick();
        chk_stats(10'd2);
        tick(); tick();
        rd(10'd2, 32'hCAFEF00E, 1'b0, 1'b1, 1'b0);
        tick();
        chk_stats(10'd2);

        // back-to-back corrections under busy writes: second is dropped, then cancel via write to 4
        corrupt_wr(10'd4, 32'h44444444, 39'd1 << 20);
        corrupt_wr(10'd6, 32'h66666666, 39'd1 << 7);
        write_en = 1'b1; write_addr = 10'd20; write_data = 32'h20202020;
        rd(10'd4, 32'h44444444, 1'b1, 1'b0, 1'b0);
        rd(10'd6, 32'h66666666, 1'b1, 1'b0, 1'b1);
        tick();
        write_addr = 10'd4; write_data = 32'h0BADCAFE;
        tick();
        write_en = 1'b0;
        tick(); tick();
        rd(10'd4, 32'h0BADCAFE, 1'b0, 1'b0, 1'b0);
        rd(10'd6, 32'h66666666, 1'b1, 1'b0, 1'b0);
        tick(); tick();
        rd(10'd6, 32'h66666666, 1'b0, 1'b0, 1'b0);
        tick();
        chk_stats(10'd6);

        // read-during-write bypass
        wr(10'd7, 32'h11111111);
        write_en = 1'b1; write_addr = 10'd7; write_data = 32'hA5A5A5A5;
        rd(10'd7, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);
        write_en = 1'b0;
        rd(10'd7, 32'hA5A5A5A5, 1'b0, 1'b0, 1'b0);

        // saturate corr_count while the scrubber is blocked, then reset mid-pending
        corrupt_wr(10'd30, 32'h55AA33CC, 39'd1 << 10);
        write_en = 1'b1; write_addr = 10'd31; write_data = 32'h0;
        for (int i = 0; i < 70; i++) begin
            rd(10'd30, 32'h55AA33CC, 1'b1, 1'b0, (i != 0));
        end
        tick();
        chk_stats(10'd30);
        write_en = 1'b0;
        reset = 1'b1; read_en = 1'b1; read_addr = 10'd30;
        expect_read(32'd0, 1'b0, 1'b0, 1'b0);
        tick();
        read_en = 1'b0;
        m_corr = 0; m_unc = 0;
        chk_stats(10'd0);
        reset = 1'b0;
        tick(); tick(); tick();
        rd(10'd30, 32'h55AA33CC, 1'b1, 1'b0, 1'b0);
        tick();
        chk_stats(10'd30);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
